// File: rtl/cpl_timeout_tracker.sv
// Tracks issue timestamps of non-posted request tags, clears them on completion, and
// reports tags whose age reaches TIMEOUT through a round-robin scanner (valid/ready).
// Optional macro CTT_TIMEOUT_CNT_EN enables the saturating accepted-report counter.
module cpl_timeout_tracker #(
    parameter int WIDTH   = 44,
    parameter int TAGS    = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] now,
    input  logic             issue_valid,
    input  logic [TAG_W-1:0] issue_tag,
    input  logic             cpl_valid,
    input  logic [TAG_W-1:0] cpl_tag,
    output logic             timeout_valid,
    output logic [TAG_W-1:0] timeout_tag,
    input  logic             timeout_ready,
    output logic [TAG_W:0]   outstanding,
    output logic             dup_issue,
    output logic             unexp_cpl,
    output logic [15:0]      timeout_count
);
    typedef enum logic {SCAN, REPORT} state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_T = WIDTH'(TIMEOUT);

    state_t             state_q, state_d;
    logic [TAGS-1:0]    live_q, live_d;
    logic [WIDTH-1:0]   start_q [TAGS];
    logic [WIDTH-1:0]   start_d [TAGS];
    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic               timeout_valid_q, timeout_valid_d;
    logic [TAG_W-1:0]   timeout_tag_q, timeout_tag_d;
    logic [TAG_W:0]     outstanding_q, outstanding_d;
    logic               dup_issue_q, dup_issue_d;
    logic               unexp_cpl_q, unexp_cpl_d;

    logic               issue_live, cpl_live, cpl_hit, expired, accept;
    logic [WIDTH-1:0]   age;

    assign issue_live = live_q[issue_tag];
    assign cpl_live   = live_q[cpl_tag];
    assign cpl_hit    = cpl_valid && cpl_live;
    // Modular subtraction keeps the age correct across counter wrap.
    assign age        = now - start_q[ptr_q];
    // A completion landing on the scanned tag in the same cycle suppresses the report.
    assign expired    = live_q[ptr_q] && (age >= TIMEOUT_T) && !(cpl_hit && (cpl_tag == ptr_q));
    assign accept     = timeout_valid_q && timeout_ready;

    always_comb begin
        state_d         = state_q;
        live_d          = live_q;
        start_d         = start_q;
        ptr_d           = ptr_q;
        timeout_valid_d = timeout_valid_q;
        timeout_tag_d   = timeout_tag_q;
        dup_issue_d     = issue_valid && issue_live;
        unexp_cpl_d     = cpl_valid && !cpl_live;

        if (cpl_hit) begin
            live_d[cpl_tag] = 1'b0;
        end
        if (issue_valid && !issue_live) begin
            live_d[issue_tag]  = 1'b1;
            start_d[issue_tag] = now;
        end

        case (state_q)
            SCAN: begin
                if (expired) begin
                    live_d[ptr_q]   = 1'b0;
                    timeout_tag_d   = ptr_q;
                    timeout_valid_d = 1'b1;
                    state_d         = REPORT;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            REPORT: begin
                if (accept) begin
                    timeout_valid_d = 1'b0;
                    ptr_d           = ptr_q + 1'b1;
                    state_d         = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase

        outstanding_d = '0;
        for (int i = 0; i < TAGS; i++) begin
            outstanding_d = outstanding_d + (TAG_W+1)'(live_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= SCAN;
            live_q          <= '0;
            ptr_q           <= '0;
            timeout_valid_q <= 1'b0;
            timeout_tag_q   <= '0;
            outstanding_q   <= '0;
            dup_issue_q     <= 1'b0;
            unexp_cpl_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            live_q          <= live_d;
            ptr_q           <= ptr_d;
            timeout_valid_q <= timeout_valid_d;
            timeout_tag_q   <= timeout_tag_d;
            outstanding_q   <= outstanding_d;
            dup_issue_q     <= dup_issue_d;
            unexp_cpl_q     <= unexp_cpl_d;
        end
    end

    // Timestamps are only meaningful while the live bit is set, so they carry no reset.
    always_ff @(posedge clk) begin
        start_q <= start_d;
    end

    assign timeout_valid = timeout_valid_q;
    assign timeout_tag   = timeout_tag_q;
    assign outstanding   = outstanding_q;
    assign dup_issue     = dup_issue_q;
    assign unexp_cpl     = unexp_cpl_q;

`ifdef CTT_TIMEOUT_CNT_EN
    logic [15:0] timeout_count_q, timeout_count_d;

    always_comb begin
        timeout_count_d = timeout_count_q;
        if (accept && (timeout_count_q != 16'hFFFF)) begin
            timeout_count_d = timeout_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_count_q <= '0;
        end else begin
            timeout_count_q <= timeout_count_d;
        end
    end

    assign timeout_count = timeout_count_q;
`else
    assign timeout_count = '0;
`endif
endmodule
